// File: rtl/row_request_gen_mc_if.sv
// rtl/row_request_gen_mc_if.sv - row-request AXI-Stream transmit interface
interface row_request_gen_mc_if #(
    parameter int TDATA_W = 256
);
    logic [TDATA_W-1:0] AXIS_TX_TDATA;
    logic               AXIS_TX_TVALID;
    logic               AXIS_TX_TLAST;
    logic               AXIS_TX_TREADY;

    modport master (
        output AXIS_TX_TDATA,
        output AXIS_TX_TVALID,
        output AXIS_TX_TLAST,
        input  AXIS_TX_TREADY
    );

    modport slave (
        input  AXIS_TX_TDATA,
        input  AXIS_TX_TVALID,
        input  AXIS_TX_TLAST,
        output AXIS_TX_TREADY
    );
endinterface

// File: rtl/row_request_gen_mc.sv
// rtl/row_request_gen_mc.sv - throttled row-request packet generator with abort and completion drain
module row_request_gen_mc #(
    parameter int          TDATA_W         = 256,
    parameter int          CNT_W           = 64,
    parameter int          MAX_OUTSTANDING = 16,
    parameter logic [7:0]  PKT_TYPE        = 8'h00,
    parameter int          ROW_REQ_OFFS    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [31:0]      cfg_base_row,
    input  logic [15:0]      cfg_stride,
    input  logic             cfg_continuous,
    input  logic             start,
    input  logic             abort,
    input  logic             row_complete_in,
    output logic             active,
    output logic             done,
    output logic             overflow_err,
    output logic [CNT_W-1:0] requests_sent,
    output logic [CNT_W-1:0] requests_completed,
    row_request_gen_mc_if.master axis_tx
);
    localparam int               OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, FINISH} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   pass_idx;
    logic [31:0]        base_r;
    logic [31:0]        row_r;
    logic [15:0]        stride_r;
    logic               cont_r;
    logic               abort_pending;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   out_next;
    logic [TDATA_W-1:0] tdata;
    logic               tvalid;
    logic               hs;
    logic               cmp_ok;
    logic               pass_last;
    logic [31:0]        row_adv;

    function automatic logic [TDATA_W-1:0] pack_row(input logic [31:0] row);
        logic [TDATA_W-1:0] d;
        d                      = '0;
        d[7:0]                 = PKT_TYPE;
        d[ROW_REQ_OFFS +: 32]  = row;
        return d;
    endfunction

    assign hs        = tvalid && axis_tx.AXIS_TX_TREADY;
    assign cmp_ok    = row_complete_in && (state != IDLE) && (outstanding != '0);
    assign pass_last = (pass_idx == cnt_r - CNT_W'(1));
    assign row_adv   = row_r + {16'b0, stride_r};

    // A handshake and a completion in the same cycle cancel out.
    always_comb begin
        out_next = outstanding;
        if (hs && !cmp_ok)
            out_next = outstanding + OUT_W'(1);
        else if (!hs && cmp_ok)
            out_next = outstanding - OUT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cnt_r              <= '0;
            pass_idx           <= '0;
            base_r             <= '0;
            row_r              <= '0;
            stride_r           <= '0;
            cont_r             <= 1'b0;
            abort_pending      <= 1'b0;
            outstanding        <= '0;
            tdata              <= '0;
            tvalid             <= 1'b0;
            done               <= 1'b0;
            overflow_err       <= 1'b0;
            requests_sent      <= '0;
            requests_completed <= '0;
        end else begin
            done        <= 1'b0;
            outstanding <= out_next;
            if (cmp_ok)
                requests_completed <= requests_completed + CNT_W'(1);
            if (row_complete_in && outstanding == '0)
                overflow_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        cnt_r              <= cfg_count;
                        base_r             <= cfg_base_row;
                        stride_r           <= cfg_stride;
                        cont_r             <= cfg_continuous;
                        row_r              <= cfg_base_row;
                        pass_idx           <= '0;
                        tdata              <= pack_row(cfg_base_row);
                        abort_pending      <= 1'b0;
                        requests_sent      <= '0;
                        requests_completed <= '0;
                        overflow_err       <= row_complete_in;
                        if (cfg_count == '0) begin
                            state <= DRAIN;
                        end else begin
                            state  <= SEND;
                            tvalid <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (hs) begin
                        requests_sent <= requests_sent + CNT_W'(1);
                        if ((pass_last && !cont_r) || abort || abort_pending) begin
                            state         <= DRAIN;
                            tvalid        <= 1'b0;
                            abort_pending <= 1'b0;
                        end else begin
                            if (pass_last) begin
                                row_r    <= base_r;
                                pass_idx <= '0;
                                tdata    <= pack_row(base_r);
                            end else begin
                                row_r    <= row_adv;
                                pass_idx <= pass_idx + CNT_W'(1);
                                tdata    <= pack_row(row_adv);
                            end
                            tvalid <= (out_next < MAX_OUT);
                        end
                    end else if (tvalid) begin
                        // Beat is committed; abort must wait for its handshake.
                        if (abort)
                            abort_pending <= 1'b1;
                    end else if (abort) begin
                        state <= DRAIN;
                    end else begin
                        tvalid <= (out_next < MAX_OUT);
                    end
                end
                DRAIN: begin
                    tvalid <= 1'b0;
                    if (out_next == '0) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign active                 = (state != IDLE);
    assign axis_tx.AXIS_TX_TDATA  = tdata;
    assign axis_tx.AXIS_TX_TVALID = tvalid;
    assign axis_tx.AXIS_TX_TLAST  = 1'b1;
endmodule

// File: tb/tb_row_request_gen_mc.sv
// tb/tb_row_request_gen_mc.sv - directed bench for row_request_gen_mc
module tb_row_request_gen_mc;
    localparam int TDATA_W = 256;
    localparam int CNT_W   = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] cfg_count;
    logic [31:0]      cfg_base_row;
    logic [15:0]      cfg_stride;
    logic             cfg_continuous;
    logic             start;
    logic             abort;
    logic             row_complete_in;
    logic             active;
    logic             done;
    logic             overflow_err;
    logic [CNT_W-1:0] requests_sent;
    logic [CNT_W-1:0] requests_completed;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] beat_q[$];
    logic [31:0] exp_rows[7];

    always #5 clk = ~clk;

    row_request_gen_mc_if #(.TDATA_W(TDATA_W)) axis_tx ();

    row_request_gen_mc #(
        .TDATA_W(TDATA_W), .CNT_W(CNT_W), .MAX_OUTSTANDING(16),
        .PKT_TYPE(8'h00), .ROW_REQ_OFFS(8)
    ) u_dut (
        .clk(clk), .reset(reset),
        .cfg_count(cfg_count), .cfg_base_row(cfg_base_row),
        .cfg_stride(cfg_stride), .cfg_continuous(cfg_continuous),
        .start(start), .abort(abort), .row_complete_in(row_complete_in),
        .active(active), .done(done), .overflow_err(overflow_err),
        .requests_sent(requests_sent), .requests_completed(requests_completed),
        .axis_tx(axis_tx)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pkt(input logic [31:0] row);
        logic [255:0] d;
        d        = '0;
        d[39:8]  = row;
        return d;
    endfunction

    // Records each accepted beat just before the edge that accepts it.
    always @(negedge clk) begin
        #4;
        if (!reset && axis_tx.AXIS_TX_TVALID && axis_tx.AXIS_TX_TREADY)
            beat_q.push_back(axis_tx.AXIS_TX_TDATA[39:8]);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start_run(input logic [CNT_W-1:0] cnt, input logic [31:0] base,
                             input logic [15:0] stride, input logic cont);
        cfg_count      = cnt;
        cfg_base_row   = base;
        cfg_stride     = stride;
        cfg_continuous = cont;
        start          = 1'b1;
        cyc();
        start          = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; row_complete_in = 1'b0;
        cfg_count = '0; cfg_base_row = '0; cfg_stride = '0; cfg_continuous = 1'b0;
        axis_tx.AXIS_TX_TREADY = 1'b1;
        cyc(3);
        check("rst_tvalid", 256'(axis_tx.AXIS_TX_TVALID), 256'(0));
        check("rst_tdata", axis_tx.AXIS_TX_TDATA, 256'(0));
        check("rst_active", 256'(active), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_ovf", 256'(overflow_err), 256'(0));
        check("rst_sent", 256'(requests_sent), 256'(0));
        check("rst_comp", 256'(requests_completed), 256'(0));
        reset = 1'b0;
        cyc(2);

        // 1: simple run of four rows
        beat_q.delete();
        start_run(4, 32'hC008, 16'd1, 1'b0);
        check("t1_first_valid", 256'(axis_tx.AXIS_TX_TVALID), 256'(1));
        check("t1_first_data", axis_tx.AXIS_TX_TDATA, pkt(32'hC008));
        check("t1_tlast", 256'(axis_tx.AXIS_TX_TLAST), 256'(1));
        cyc(5);
        check("t1_nbeats", 256'(beat_q.size()), 256'(4));
        for (int i = 0; i < 4 && i < beat_q.size(); i++)
            check("t1_row", 256'(beat_q[i]), 256'(32'hC008 + 32'(i)));
        check("t1_idle_valid", 256'(axis_tx.AXIS_TX_TVALID), 256'(0));
        check("t1_active", 256'(active), 256'(1));
        for (int i = 0; i < 4; i++) begin
            row_complete_in = 1'b1;
            cyc();
            row_complete_in = 1'b0;
            if (i < 3) check("t1_no_early_done", 256'(done), 256'(0));
        end
        check("t1_done", 256'(done), 256'(1));
        check("t1_sent", 256'(requests_sent), 256'(4));
        check("t1_comp", 256'(requests_completed), 256'(4));
        cyc();
        check("t1_done_pulse", 256'(done), 256'(0));
        check("t1_inactive", 256'(active), 256'(0));

        // 2: throttle at 16 outstanding
        beat_q.delete();
        start_run(40, 32'h100, 16'd2, 1'b0);
        cyc(30);
        check("t2_throttle_beats", 256'(beat_q.size()), 256'(16));
        check("t2_throttle_valid", 256'(axis_tx.AXIS_TX_TVALID), 256'(0));
        check("t2_sent16", 256'(requests_sent), 256'(16));
        row_complete_in = 1'b1;
        cyc();
        row_complete_in = 1'b0;
        check("t2_release_valid", 256'(axis_tx.AXIS_TX_TVALID), 256'(1));
        cyc(3);
        check("t2_one_more", 256'(beat_q.size()), 256'(17));
        if (beat_q.size() > 16) check("t2_row17", 256'(beat_q[16]), 256'(32'h120));
        for (int i = 0; i < 39; i++) begin
            row_complete_in = 1'b1;
            cyc();
        end
        row_complete_in = 1'b0;
        check("t2_done", 256'(done), 256'(1));
        check("t2_sent", 256'(requests_sent), 256'(40));
        check("t2_comp", 256'(requests_completed), 256'(40));
        check("t2_nbeats", 256'(beat_q.size()), 256'(40));
        if (beat_q.size() == 40) check("t2_last_row", 256'(beat_q[39]), 256'(32'h14E));
        check("t2_ovf", 256'(overflow_err), 256'(0));
        cyc(2);

        // 3: backpressure with abort during a pending beat
        beat_q.delete();
        axis_tx.AXIS_TX_TREADY = 1'b0;
        start_run(5, 32'h500, 16'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 256'(axis_tx.AXIS_TX_TVALID), 256'(1));
            check("t3_hold_data", axis_tx.AXIS_TX_TDATA, pkt(32'h500));
            abort = (i == 1);
            cyc();
        end
        abort = 1'b0;
        axis_tx.AXIS_TX_TREADY = 1'b1;
        cyc();
        check("t3_drain_valid", 256'(axis_tx.AXIS_TX_TVALID), 256'(0));
        check("t3_sent", 256'(requests_sent), 256'(1));
        cyc(4);
        check("t3_nbeats", 256'(beat_q.size()), 256'(1));
        check("t3_still_active", 256'(active), 256'(1));
        row_complete_in = 1'b1;
        cyc();
        row_complete_in = 1'b0;
        check("t3_done", 256'(done), 256'(1));
        cyc(2);

        // 4: continuous mode with 32-bit row wrap, stopped by abort
        beat_q.delete();
        start_run(3, 32'hFFFF_FFFE, 16'd1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            if (beat_q.size() >= 6) break;
            cyc();
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc(3);
        exp_rows = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE,
                     32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE};
        check("t4_nbeats", 256'(beat_q.size()), 256'(7));
        for (int i = 0; i < 7 && i < beat_q.size(); i++)
            check("t4_row", 256'(beat_q[i]), 256'(exp_rows[i]));
        check("t4_sent", 256'(requests_sent), 256'(7));
        for (int i = 0; i < 7; i++) begin
            row_complete_in = 1'b1;
            cyc();
        end
        row_complete_in = 1'b0;
        check("t4_done", 256'(done), 256'(1));
        cyc(2);

        // 5: completion with nothing outstanding
        row_complete_in = 1'b1;
        cyc();
        row_complete_in = 1'b0;
        check("t5_ovf_set", 256'(overflow_err), 256'(1));
        check("t5_sent_kept", 256'(requests_sent), 256'(7));
        check("t5_comp_kept", 256'(requests_completed), 256'(7));
        cyc(3);
        check("t5_ovf_sticky", 256'(overflow_err), 256'(1));

        // 6: zero-count run, then asynchronous reset mid-send
        start_run(0, 32'h10, 16'd1, 1'b0);
        check("t6_ovf_cleared", 256'(overflow_err), 256'(0));
        check("t6_no_valid", 256'(axis_tx.AXIS_TX_TVALID), 256'(0));
        check("t6_done_early", 256'(done), 256'(0));
        check("t6_active", 256'(active), 256'(1));
        cyc();
        check("t6_done", 256'(done), 256'(1));
        cyc();
        check("t6_done_pulse", 256'(done), 256'(0));
        check("t6_idle", 256'(active), 256'(0));

        axis_tx.AXIS_TX_TREADY = 1'b0;
        start_run(10, 32'h40, 16'd1, 1'b0);
        check("t6_send_valid", 256'(axis_tx.AXIS_TX_TVALID), 256'(1));
        reset = 1'b1;
        #1;
        check("t6_async_valid", 256'(axis_tx.AXIS_TX_TVALID), 256'(0));
        check("t6_async_active", 256'(active), 256'(0));
        check("t6_async_tdata", axis_tx.AXIS_TX_TDATA, 256'(0));
        cyc();
        reset = 1'b0;
        cyc(2);
        check("t6_post_reset_valid", 256'(axis_tx.AXIS_TX_TVALID), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
